imem_sync: RTL and testbench

- Parametrised, synchronous instruction memory for the pipelined CPU; next generation of the single-cycle combinational ROM.
- Contents are loaded at run time through a program-load port instead of being fixed constants.
- Fetches use a valid/ready request and a fixed-latency response pipeline, with a flush for branch redirects.
- Faults are flagged for out-of-range and misaligned addresses.

---
 rtl/imem_sync.sv | 153 +++++++++++++++
 tb/tb_imem_sync.sv | 264 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/imem_sync.sv
// Synchronous instruction memory for the pipelined CPU: runtime-loadable storage,
// valid/ready fetch with a fixed LAT-cycle response pipeline, flush and fault flags.
module imem_sync #(
  parameter int                ADDR_W    = 32,
  parameter int                DATA_W    = 32,
  parameter int                DEPTH     = 64,
  parameter int                LAT       = 1,
  parameter int                BYTE_ADDR = 0,
  parameter logic [DATA_W-1:0] FILL      = '0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic              flush,
  output logic              rsp_valid,
  output logic [DATA_W-1:0] rsp_ins,
  output logic [1:0]        rsp_fault,
  input  logic              ld_en,
  input  logic [ADDR_W-1:0] ld_addr,
  input  logic [DATA_W-1:0] ld_data,
  output logic              ld_err
);

  localparam int                IDX_W   = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [ADDR_W-1:0] DEPTH_A = ADDR_W'(DEPTH);

  // Out-of-range fetches never expose array contents.
  function automatic logic [DATA_W-1:0] fillIfOor(input logic oor, input logic [DATA_W-1:0] word);
    return oor ? FILL : word;
  endfunction

  logic [DATA_W-1:0] mem [DEPTH];

  logic              accept;
  logic [ADDR_W-1:0] fetchIdx;
  logic              fetchOor;
  logic              fetchMis;
  logic [IDX_W-1:0]  rdIdx;
  logic [DATA_W-1:0] accIns;
  logic [1:0]        accFault;

  logic              ldInRange;
  logic [IDX_W-1:0]  ldIdx;

  logic              tailVld;
  logic              tailKill;
  logic [DATA_W-1:0] tailIns;
  logic [1:0]        tailFault;

  assign req_ready = ~ld_en;
  assign accept    = req_valid & req_ready;

  // Range check runs on the full-width index so high address bits cannot alias.
  assign fetchIdx = (BYTE_ADDR != 0) ? (req_addr >> 2) : req_addr;
  assign fetchMis = (BYTE_ADDR != 0) && (req_addr[1:0] != 2'b00);
  assign fetchOor = (fetchIdx >= DEPTH_A);
  assign rdIdx    = fetchOor ? '0 : fetchIdx[IDX_W-1:0];
  assign accIns   = fillIfOor(fetchOor, mem[rdIdx]);
  assign accFault = {fetchMis, fetchOor};

  assign ldInRange = (ld_addr < DEPTH_A);
  assign ldIdx     = ld_addr[IDX_W-1:0];

  always_ff @(posedge clk) begin
    if (ld_en && ldInRange) begin
      mem[ldIdx] <= ld_data;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ld_err <= 1'b0;
    end else begin
      ld_err <= ld_en & ~ldInRange;
    end
  end

  // With LAT=1 the only stage is the response itself, which always carries the
  // accepted redirect target, so flush has nothing to kill there.
  assign tailKill = (LAT > 1) ? flush : 1'b0;

  generate
    if (LAT == 1) begin : gLat1
      assign tailVld   = accept;
      assign tailIns   = accIns;
      assign tailFault = accFault;
    end else begin : gLatN
      logic              vld_p1;
      logic [DATA_W-1:0] ins_p1;
      logic [1:0]        fault_p1;

      // ---- stage p1: loaded at the accept edge; a same-cycle flush keeps it ----
      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          vld_p1 <= 1'b0;
        end else begin
          vld_p1 <= accept;
        end
      end

      always_ff @(posedge clk) begin
        ins_p1   <= accIns;
        fault_p1 <= accFault;
      end

      if (LAT == 2) begin : gLat2
        assign tailVld   = vld_p1;
        assign tailIns   = ins_p1;
        assign tailFault = fault_p1;
      end else begin : gLat3
        logic              vld_p2;
        logic [DATA_W-1:0] ins_p2;
        logic [1:0]        fault_p2;

        // ---- stage p2 ----
        always_ff @(posedge clk or posedge rst) begin
          if (rst) begin
            vld_p2 <= 1'b0;
          end else begin
            vld_p2 <= vld_p1 & ~flush;
          end
        end

        always_ff @(posedge clk) begin
          ins_p2   <= ins_p1;
          fault_p2 <= fault_p1;
        end

        assign tailVld   = vld_p2;
        assign tailIns   = ins_p2;
        assign tailFault = fault_p2;
      end
    end
  endgenerate

  // ---- response stage: payload only moves with a surviving valid, so it holds otherwise ----
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rsp_valid <= 1'b0;
      rsp_ins   <= FILL;
      rsp_fault <= 2'b00;
    end else begin
      rsp_valid <= tailVld & ~tailKill;
      if (tailVld && !tailKill) begin
        rsp_ins   <= tailIns;
        rsp_fault <= tailFault;
      end
    end
  end

endmodule

// File: tb/tb_imem_sync.sv
// Scoreboard bench for imem_sync: three instances (LAT=1 word, LAT=3 word, LAT=2 byte)
// driven with directed vectors; a negedge monitor pops and checks every response.
module tb_imem_sync;

  localparam int          LAT_A  = 1;
  localparam int          LAT_B  = 3;
  localparam int          LAT_C  = 2;
  localparam logic [31:0] FILL_C = 32'h0000_0013;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  logic        reqValid [3];
  logic        reqReady [3];
  logic [31:0] reqAddr  [3];
  logic        flush    [3];
  logic        rspValid [3];
  logic [31:0] rspIns   [3];
  logic [1:0]  rspFault [3];
  logic        ldEn     [3];
  logic [31:0] ldAddr   [3];
  logic [31:0] ldData   [3];
  logic        ldErr    [3];

  logic [31:0] prog [10] = '{32'h0000008e, 32'h0000010e, 32'h00110102, 32'h0000018e, 32'h06518182,
                             32'h00208081, 32'h00110102, 32'hfe310f11, 32'h00008f82, 32'h00000012};

  imem_sync #(.ADDR_W(32), .DATA_W(32), .DEPTH(10), .LAT(LAT_A), .BYTE_ADDR(0), .FILL(32'h0)) dutA (
    .clk(clk), .rst(rst), .req_valid(reqValid[0]), .req_ready(reqReady[0]), .req_addr(reqAddr[0]),
    .flush(flush[0]), .rsp_valid(rspValid[0]), .rsp_ins(rspIns[0]), .rsp_fault(rspFault[0]),
    .ld_en(ldEn[0]), .ld_addr(ldAddr[0]), .ld_data(ldData[0]), .ld_err(ldErr[0]));

  imem_sync #(.ADDR_W(32), .DATA_W(32), .DEPTH(10), .LAT(LAT_B), .BYTE_ADDR(0), .FILL(32'h0)) dutB (
    .clk(clk), .rst(rst), .req_valid(reqValid[1]), .req_ready(reqReady[1]), .req_addr(reqAddr[1]),
    .flush(flush[1]), .rsp_valid(rspValid[1]), .rsp_ins(rspIns[1]), .rsp_fault(rspFault[1]),
    .ld_en(ldEn[1]), .ld_addr(ldAddr[1]), .ld_data(ldData[1]), .ld_err(ldErr[1]));

  imem_sync #(.ADDR_W(32), .DATA_W(32), .DEPTH(10), .LAT(LAT_C), .BYTE_ADDR(1), .FILL(FILL_C)) dutC (
    .clk(clk), .rst(rst), .req_valid(reqValid[2]), .req_ready(reqReady[2]), .req_addr(reqAddr[2]),
    .flush(flush[2]), .rsp_valid(rspValid[2]), .rsp_ins(rspIns[2]), .rsp_fault(rspFault[2]),
    .ld_en(ldEn[2]), .ld_addr(ldAddr[2]), .ld_data(ldData[2]), .ld_err(ldErr[2]));

  typedef struct {
    logic [31:0] ins;
    logic [1:0]  fault;
    int          cyc;
  } exp_t;

  exp_t q0[$];
  exp_t q1[$];
  exp_t q2[$];

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %h, expected %h", name, act, req);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Expected response is due `lat` cycles after the cycle in which the request is presented.
  task automatic push(input int d, input logic [31:0] ins, input logic [1:0] f, input int lat);
    exp_t e;
    e.ins   = ins;
    e.fault = f;
    e.cyc   = cyc + lat;
    case (d)
      0:       q0.push_back(e);
      1:       q1.push_back(e);
      default: q2.push_back(e);
    endcase
  endtask

  task automatic fetch(input int d, input logic [31:0] addr, input logic [31:0] ins,
                       input logic [1:0] f, input int lat, input bit expect_rsp);
    reqValid[d] = 1'b1;
    reqAddr[d]  = addr;
    if (expect_rsp) push(d, ins, f, lat);
    tick();
  endtask

  task automatic drain();
    for (int i = 0; i < 40; i++) begin
      if (q0.size() == 0 && q1.size() == 0 && q2.size() == 0) break;
      tick();
    end
    repeat (4) tick();
  endtask

  // Monitor: every presented response must match the oldest expectation, on its due cycle.
  exp_t monE;
  bit   monHave;
  initial begin
    forever begin
      @(negedge clk);
      for (int d = 0; d < 3; d++) begin
        if (rspValid[d] === 1'b1) begin
          monHave = 1'b0;
          if (d == 0 && q0.size() > 0) begin monE = q0.pop_front(); monHave = 1'b1; end
          if (d == 1 && q1.size() > 0) begin monE = q1.pop_front(); monHave = 1'b1; end
          if (d == 2 && q2.size() > 0) begin monE = q2.pop_front(); monHave = 1'b1; end
          check($sformatf("rsp%0d_expected", d), 32'(monHave), 32'd1);
          if (monHave) begin
            check($sformatf("rsp%0d_ins", d), rspIns[d], monE.ins);
            check($sformatf("rsp%0d_fault", d), 32'(rspFault[d]), 32'(monE.fault));
            check($sformatf("rsp%0d_cycle", d), 32'(cyc), 32'(monE.cyc));
          end
        end
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    for (int d = 0; d < 3; d++) begin
      reqValid[d] = 1'b0; reqAddr[d] = '0; flush[d] = 1'b0;
      ldEn[d] = 1'b0; ldAddr[d] = '0; ldData[d] = '0;
    end
    #1 rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    for (int d = 0; d < 3; d++) begin
      check($sformatf("reset%0d_rsp_valid", d), 32'(rspValid[d]), 32'd0);
      check($sformatf("reset%0d_rsp_ins", d), rspIns[d], (d == 2) ? FILL_C : 32'h0);
      check($sformatf("reset%0d_rsp_fault", d), 32'(rspFault[d]), 32'd0);
      check($sformatf("reset%0d_ld_err", d), 32'(ldErr[d]), 32'd0);
      check($sformatf("reset%0d_req_ready", d), 32'(reqReady[d]), 32'd1);
    end
    rst = 1'b0;
    tick();

    // Program load into all three instances.
    for (int i = 0; i < 10; i++) begin
      for (int d = 0; d < 3; d++) begin
        ldEn[d] = 1'b1; ldAddr[d] = 32'(i); ldData[d] = prog[i];
      end
      #1;
      if (i == 0) check("req_ready_low_on_load", 32'(reqReady[0]), 32'd0);
      tick();
    end
    for (int d = 0; d < 3; d++) ldEn[d] = 1'b0;

    // LAT=1: back-to-back fetch of the whole program.
    for (int i = 0; i < 10; i++) fetch(0, 32'(i), prog[i], 2'b00, LAT_A, 1'b1);
    reqValid[0] = 1'b0;
    drain();

    // Out-of-range loads: pulse on ld_err, no write (including a wide address that would alias 9).
    ldEn[0] = 1'b1; ldAddr[0] = 32'd10; ldData[0] = 32'hbad0_bad0;
    tick();
    check("ld_err_pulse", 32'(ldErr[0]), 32'd1);
    ldAddr[0] = 32'h1000_0009;
    tick();
    check("ld_err_wide", 32'(ldErr[0]), 32'd1);
    ldEn[0] = 1'b0;
    tick();
    check("ld_err_clear", 32'(ldErr[0]), 32'd0);
    fetch(0, 32'd9, 32'h00000012, 2'b00, LAT_A, 1'b1);
    fetch(0, 32'd0, 32'h0000008e, 2'b00, LAT_A, 1'b1);
    reqValid[0] = 1'b0;
    drain();

    // LAT=3 flush. The response for 1 is already on the output in the flush cycle, so it
    // survives; 2 (due at the flush edge) and 3 are killed; the redirect target 7 is kept.
    fetch(1, 32'd1, 32'h0000010e, 2'b00, LAT_B, 1'b1);
    fetch(1, 32'd2, 32'h0, 2'b00, LAT_B, 1'b0);
    fetch(1, 32'd3, 32'h0, 2'b00, LAT_B, 1'b0);
    flush[1] = 1'b1;
    fetch(1, 32'd7, 32'hfe310f11, 2'b00, LAT_B, 1'b1);
    reqValid[1] = 1'b0; flush[1] = 1'b0;
    drain();
    // Flush alone with two fetches in flight: nothing comes out and the payload holds.
    fetch(1, 32'd4, 32'h0, 2'b00, LAT_B, 1'b0);
    fetch(1, 32'd5, 32'h0, 2'b00, LAT_B, 1'b0);
    reqValid[1] = 1'b0; flush[1] = 1'b1;
    tick();
    flush[1] = 1'b0;
    drain();
    check("rsp_ins_hold_flush", rspIns[1], 32'hfe310f11);
    fetch(1, 32'd8, 32'h00008f82, 2'b00, LAT_B, 1'b1);
    reqValid[1] = 1'b0;
    drain();

    // Byte-addressed faults.
    fetch(2, 32'd40, FILL_C, 2'b01, LAT_C, 1'b1);
    fetch(2, 32'd6, 32'h0000010e, 2'b10, LAT_C, 1'b1);
    fetch(2, 32'd42, FILL_C, 2'b11, LAT_C, 1'b1);
    fetch(2, 32'h1000_0004, FILL_C, 2'b01, LAT_C, 1'b1);
    fetch(2, 32'd39, 32'h00000012, 2'b10, LAT_C, 1'b1);
    fetch(2, 32'd36, 32'h00000012, 2'b00, LAT_C, 1'b1);
    reqValid[2] = 1'b0;
    drain();
    check("rsp_ins_hold_idle", rspIns[2], 32'h00000012);

    // Load has priority over a pending fetch.
    ldEn[2] = 1'b1; ldAddr[2] = 32'd5; ldData[2] = 32'h00208081;
    reqValid[2] = 1'b1; reqAddr[2] = 32'd8;
    #1;
    check("req_ready_priority", 32'(reqReady[2]), 32'd0);
    tick();
    ldEn[2] = 1'b0; reqValid[2] = 1'b0;

    // Data is sampled at accept: a following load to the same index does not leak in.
    fetch(2, 32'd16, 32'h06518182, 2'b00, LAT_C, 1'b1);
    reqValid[2] = 1'b0;
    ldEn[2] = 1'b1; ldAddr[2] = 32'd4; ldData[2] = 32'hdeadbeef;
    tick();
    ldEn[2] = 1'b0;
    drain();
    fetch(2, 32'd16, 32'hdeadbeef, 2'b00, LAT_C, 1'b1);
    reqValid[2] = 1'b0;
    drain();

    // Asynchronous reset with one response on the output and one fetch still in flight.
    fetch(2, 32'd0, 32'h0, 2'b00, LAT_C, 1'b0);
    fetch(2, 32'd16, 32'h0, 2'b00, LAT_C, 1'b0);
    reqValid[2] = 1'b0;
    check("rsp_valid_before_reset", 32'(rspValid[2]), 32'd1);
    #1 rst = 1'b1;
    #1;
    check("async_reset_rsp_valid", 32'(rspValid[2]), 32'd0);
    check("async_reset_rsp_ins", rspIns[2], FILL_C);
    check("async_reset_rsp_fault", 32'(rspFault[2]), 32'd0);
    tick();
    tick();
    rst = 1'b0;
    drain();

    // Contents survive reset.
    fetch(2, 32'd16, 32'hdeadbeef, 2'b00, LAT_C, 1'b1);
    fetch(2, 32'd36, 32'h00000012, 2'b00, LAT_C, 1'b1);
    reqValid[2] = 1'b0;
    fetch(0, 32'd3, 32'h0000018e, 2'b00, LAT_A, 1'b1);
    reqValid[0] = 1'b0;
    fetch(1, 32'd7, 32'hfe310f11, 2'b00, LAT_B, 1'b1);
    reqValid[1] = 1'b0;
    drain();

    check("pending_rsp0", 32'(q0.size()), 32'd0);
    check("pending_rsp1", 32'(q1.size()), 32'd0);
    check("pending_rsp2", 32'(q2.size()), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
